// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory req/ack access FSM, branch/jump redirect and the MEM/WB register.
// Optional access timeout with sticky Mem_Err is compiled in when MEM_TIMEOUT_EN is defined.
module mem_stage #(
  parameter int size           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ExMem_Jump,
  input  logic            ExMem_Branch,
  input  logic            ExMem_MemRead,
  input  logic            ExMem_MemtoReg,
  input  logic            ExMem_MemWrite,
  input  logic            ExMem_RegWrite,
  input  logic [size-1:0] ExMem_AluOut,
  input  logic            ExMem_ZeroFlag,
  input  logic [31:0]     ExMem_DataRt,
  input  logic [4:0]      ExMem_AddrRdRt,
  output logic            DMem_Req,
  output logic            DMem_We,
  output logic [size-1:0] DMem_Addr,
  output logic [31:0]     DMem_WData,
  input  logic            DMem_Ack,
  input  logic [31:0]     DMem_RData,
  output logic            Mem_Stall,
  output logic            PCSrc,
  output logic            Jump_Taken,
  output logic            Flush_Out,
  output logic            MemWb_RegWrite,
  output logic            MemWb_MemtoReg,
  output logic [31:0]     MemWb_ReadData,
  output logic [size-1:0] MemWb_AluOut,
  output logic [4:0]      MemWb_AddrRdRt,
  output logic [31:0]     Wb_Data,
  output logic            Mem_Err,
  output logic [1:0]      Dbg_State
);

  // Handshake: DMem_Req rises with address/we/wdata already stable and they stay
  // unchanged until the cycle DMem_Ack=1 is seen in REQ; that cycle completes the
  // access and DMem_RData is sampled. Ack seen in any other state is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state, next_state;
  logic        access, is_load, stall, timeout;
  logic [31:0] load_buf;

  assign access  = ExMem_MemRead | ExMem_MemWrite;
  assign is_load = ExMem_MemRead & ~ExMem_MemWrite;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // Fires on the last permitted REQ cycle so DMem_Req is high exactly TIMEOUT_CYCLES cycles.
  assign timeout = (state == REQ) && !DMem_Ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && access) tmo_cnt <= '0;
      else if (state == REQ && !DMem_Ack) tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end
  assign Mem_Err = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign Mem_Err = 1'b0;
`endif

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    unique case (state)
      IDLE: if (access) begin
        stall      = 1'b1;
        next_state = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (DMem_Ack || timeout) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      DMem_Req   <= 1'b0;
      DMem_We    <= 1'b0;
      DMem_Addr  <= '0;
      DMem_WData <= '0;
      load_buf   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && access) begin
        DMem_Req   <= 1'b1;
        DMem_We    <= ExMem_MemWrite;
        DMem_Addr  <= ExMem_AluOut;
        DMem_WData <= ExMem_DataRt;
      end else if (state == REQ && (DMem_Ack || timeout)) begin
        DMem_Req <= 1'b0;
      end
      if (state == REQ) begin
        if (DMem_Ack) begin
          if (!DMem_We) load_buf <= DMem_RData;
        end else if (timeout) begin
          load_buf <= 32'hDEADBEEF;
        end
      end
    end
  end

  // MEM/WB: a stalled edge inserts a bubble (RegWrite only), otherwise copy EX/MEM.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MemWb_RegWrite <= 1'b0;
      MemWb_MemtoReg <= 1'b0;
      MemWb_ReadData <= '0;
      MemWb_AluOut   <= '0;
      MemWb_AddrRdRt <= '0;
    end else if (stall) begin
      MemWb_RegWrite <= 1'b0;
    end else begin
      MemWb_RegWrite <= ExMem_RegWrite;
      MemWb_MemtoReg <= ExMem_MemtoReg;
      MemWb_AluOut   <= ExMem_AluOut;
      MemWb_AddrRdRt <= ExMem_AddrRdRt;
      if (is_load) MemWb_ReadData <= load_buf;
    end
  end

  // Stall is masked during reset so upstream stages are never frozen by stale EX/MEM bits.
  assign Mem_Stall  = RST & stall;
  assign PCSrc      = ExMem_Branch & ExMem_ZeroFlag;
  assign Jump_Taken = ExMem_Jump;
  assign Flush_Out  = (PCSrc | Jump_Taken) & ~Mem_Stall;
  assign Wb_Data    = MemWb_MemtoReg ? MemWb_ReadData : 32'(MemWb_AluOut);
  assign Dbg_State  = state;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset/timeout sequences and
// randomized ops checked against a transaction-level model of the MEM stage.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite;
  logic [31:0] ExMem_AluOut, ExMem_DataRt;
  logic        ExMem_ZeroFlag;
  logic [4:0]  ExMem_AddrRdRt;
  logic        DMem_Req, DMem_We, DMem_Ack;
  logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
  logic        Mem_Stall, PCSrc, Jump_Taken, Flush_Out;
  logic        MemWb_RegWrite, MemWb_MemtoReg;
  logic [31:0] MemWb_ReadData, MemWb_AluOut, Wb_Data;
  logic [4:0]  MemWb_AddrRdRt;
  logic        Mem_Err;
  logic [1:0]  Dbg_State;

  mem_stage #(.size(32), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .ExMem_Jump(ExMem_Jump), .ExMem_Branch(ExMem_Branch), .ExMem_MemRead(ExMem_MemRead),
    .ExMem_MemtoReg(ExMem_MemtoReg), .ExMem_MemWrite(ExMem_MemWrite), .ExMem_RegWrite(ExMem_RegWrite),
    .ExMem_AluOut(ExMem_AluOut), .ExMem_ZeroFlag(ExMem_ZeroFlag), .ExMem_DataRt(ExMem_DataRt),
    .ExMem_AddrRdRt(ExMem_AddrRdRt),
    .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr), .DMem_WData(DMem_WData),
    .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
    .Mem_Stall(Mem_Stall), .PCSrc(PCSrc), .Jump_Taken(Jump_Taken), .Flush_Out(Flush_Out),
    .MemWb_RegWrite(MemWb_RegWrite), .MemWb_MemtoReg(MemWb_MemtoReg), .MemWb_ReadData(MemWb_ReadData),
    .MemWb_AluOut(MemWb_AluOut), .MemWb_AddrRdRt(MemWb_AddrRdRt), .Wb_Data(Wb_Data),
    .Mem_Err(Mem_Err), .Dbg_State(Dbg_State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        jump, branch, zero, mr, mw, m2r, rw;
    logic [31:0] alu, drt;
    logic [4:0]  rd;
    int          delay;   // REQ cycles without ack before the ack cycle
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    op_t         op;
    int          exp_stalls;
    logic [31:0] exp_read;
    logic [31:0] exp_wb;
    logic        exp_flush;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_read;
  logic        m_err;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic op_t mk_op(input logic jump, branch, zero, mr, mw, m2r, rw,
                                input logic [31:0] alu, drt, input logic [4:0] rd,
                                input int delay, input logic [31:0] rdata);
    op_t o;
    o.jump = jump; o.branch = branch; o.zero = zero; o.mr = mr; o.mw = mw;
    o.m2r = m2r; o.rw = rw; o.alu = alu; o.drt = drt; o.rd = rd;
    o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  task automatic apply(input op_t o);
    ExMem_Jump = o.jump; ExMem_Branch = o.branch; ExMem_ZeroFlag = o.zero;
    ExMem_MemRead = o.mr; ExMem_MemWrite = o.mw; ExMem_MemtoReg = o.m2r;
    ExMem_RegWrite = o.rw; ExMem_AluOut = o.alu; ExMem_DataRt = o.drt; ExMem_AddrRdRt = o.rd;
  endtask

  // Presents one EX/MEM instruction and checks it cycle by cycle until MEM/WB has loaded it.
  task automatic run_op(input op_t o, input int exp_stalls, input logic [31:0] exp_read,
                        input logic [31:0] exp_wb, input logic exp_flush, input bit stray);
    logic st, rq;
    @(negedge CLK);
    apply(o);
    for (int c = 0; c <= exp_stalls; c++) begin
      st = (c < exp_stalls);
      rq = (c >= 1) && (c < exp_stalls);
      #1;
      check("mem_stall", Mem_Stall, st);
      check("dmem_req", DMem_Req, rq);
      check("pcsrc", PCSrc, o.branch & o.zero);
      check("jump_taken", Jump_Taken, o.jump);
      check("flush_out", Flush_Out, st ? 1'b0 : exp_flush);
      if (rq) begin
        check("dmem_addr", DMem_Addr, o.alu);
        check("dmem_we", DMem_We, o.mw);
        if (o.mw) check("dmem_wdata", DMem_WData, o.drt);
        check("bubble_regwrite", MemWb_RegWrite, 1'b0);
      end
      DMem_RData = $urandom;
      if (rq && c == 1 + o.delay) begin
        DMem_Ack = 1'b1;
        DMem_RData = o.rdata;
      end else begin
        DMem_Ack = (stray && !rq) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge CLK);
      #1;
      DMem_Ack = 1'b0;
      if (c < exp_stalls) @(negedge CLK);
    end
    check("mw_regwrite", MemWb_RegWrite, o.rw);
    check("mw_memtoreg", MemWb_MemtoReg, o.m2r);
    check("mw_aluout", MemWb_AluOut, o.alu);
    check("mw_rd", MemWb_AddrRdRt, o.rd);
    check("mw_readdata", MemWb_ReadData, exp_read);
    check("wb_data", Wb_Data, exp_wb);
    check("mem_err", Mem_Err, m_err);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req"}, DMem_Req, 1'b0);
    check({tag, "_stall"}, Mem_Stall, 1'b0);
    check({tag, "_mw_regwrite"}, MemWb_RegWrite, 1'b0);
    check({tag, "_mw_memtoreg"}, MemWb_MemtoReg, 1'b0);
    check({tag, "_mw_readdata"}, MemWb_ReadData, 32'h0);
    check({tag, "_mw_aluout"}, MemWb_AluOut, 32'h0);
    check({tag, "_mw_rd"}, MemWb_AddrRdRt, 5'd0);
    check({tag, "_wb_data"}, Wb_Data, 32'h0);
    check({tag, "_err"}, Mem_Err, 1'b0);
    check({tag, "_state"}, Dbg_State, 2'd0);
  endtask

  initial begin
    op_t  o;
    int   k, stalls;
    logic [31:0] wb;
    // ------------------------------------------------------------------ reset
    RST = 1'b0; DMem_Ack = 1'b0; DMem_RData = '0;
    apply(mk_op(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0));
    repeat (2) @(posedge CLK);
    #1;
    check_cleared("reset");
    check("reset_we", DMem_We, 1'b0);
    check("reset_addr", DMem_Addr, 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // ---------------------------------------------------------- directed table
    //                      j  b  z  mr mw m2r rw alu          drt          rd     dly rdata
    vecs[0] = '{op: mk_op(0, 0, 0, 0, 0, 0, 1, 32'h10,  32'h0,    5'd3,  0, 32'h0),
                exp_stalls: 0, exp_read: 32'h0,        exp_wb: 32'h10,       exp_flush: 1'b0};
    vecs[1] = '{op: mk_op(0, 0, 0, 1, 0, 1, 1, 32'h40,  32'h0,    5'd5,  1, 32'hCAFE0001),
                exp_stalls: 3, exp_read: 32'hCAFE0001, exp_wb: 32'hCAFE0001, exp_flush: 1'b0};
    vecs[2] = '{op: mk_op(0, 0, 0, 0, 1, 0, 0, 32'h8,   32'h55AA, 5'd0,  0, 32'h0),
                exp_stalls: 2, exp_read: 32'hCAFE0001, exp_wb: 32'h8,        exp_flush: 1'b0};
    vecs[3] = '{op: mk_op(0, 1, 1, 0, 0, 0, 0, 32'h100, 32'h0,    5'd0,  0, 32'h0),
                exp_stalls: 0, exp_read: 32'hCAFE0001, exp_wb: 32'h100,      exp_flush: 1'b1};
    vecs[4] = '{op: mk_op(0, 1, 0, 0, 0, 0, 0, 32'h104, 32'h0,    5'd0,  0, 32'h0),
                exp_stalls: 0, exp_read: 32'hCAFE0001, exp_wb: 32'h104,      exp_flush: 1'b0};
    vecs[5] = '{op: mk_op(1, 0, 0, 0, 0, 0, 0, 32'h200, 32'h0,    5'd0,  0, 32'h0),
                exp_stalls: 0, exp_read: 32'hCAFE0001, exp_wb: 32'h200,      exp_flush: 1'b1};
    vecs[6] = '{op: mk_op(0, 0, 0, 1, 1, 1, 0, 32'h80,  32'h1234, 5'd7,  1, 32'h77777777),
                exp_stalls: 3, exp_read: 32'hCAFE0001, exp_wb: 32'hCAFE0001, exp_flush: 1'b0};
    vecs[7] = '{op: mk_op(0, 1, 1, 1, 0, 1, 1, 32'h44,  32'h0,    5'd31, 0, 32'hA5A50F0F),
                exp_stalls: 2, exp_read: 32'hA5A50F0F, exp_wb: 32'hA5A50F0F, exp_flush: 1'b1};
    vecs[8] = '{op: mk_op(0, 0, 0, 1, 0, 0, 1, 32'h48,  32'h0,    5'd9,  3, 32'h0BADF00D),
                exp_stalls: 5, exp_read: 32'h0BADF00D, exp_wb: 32'h48,       exp_flush: 1'b0};
    m_err = 1'b0;
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].exp_stalls, vecs[i].exp_read, vecs[i].exp_wb, vecs[i].exp_flush, 1'b0);

    // ------------------------------------------------------ reset mid-access
    @(negedge CLK);
    apply(mk_op(0, 0, 0, 1, 0, 1, 1, 32'h60, 32'h0, 5'd4, 0, 32'h0));
    @(posedge CLK);
    #1;
    check("pre_reset_req", DMem_Req, 1'b1);
    RST = 1'b0;
    #1;
    check_cleared("midreq_reset");
    apply(mk_op(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0));
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("post_reset_state", Dbg_State, 2'd0);
    check("post_reset_stall", Mem_Stall, 1'b0);
    m_read = 32'h0;

    // ------------------------------------------------------------ random ops
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 5);
      o = mk_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                k == 1 || k == 5, k == 2 || k == 5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, TMO - 1), $urandom);
      stalls = (o.mr || o.mw) ? o.delay + 2 : 0;
      if (o.mr && !o.mw) m_read = o.rdata;
      wb = o.m2r ? m_read : o.alu;
      run_op(o, stalls, m_read, wb, (o.branch & o.zero) | o.jump, 1'b1);
    end

    // ----------------------------------------------------- unanswered request
`ifdef MEM_TIMEOUT_EN
    // Ack in the very cycle the timeout would fire: ack wins, no error.
    o = mk_op(0, 0, 0, 1, 0, 1, 1, 32'h90, 32'h0, 5'd2, TMO - 1, 32'h600D600D);
    m_read = o.rdata;
    run_op(o, TMO + 1, m_read, m_read, 1'b0, 1'b0);
    // No ack at all: request abandoned after TMO REQ cycles.
    o = mk_op(0, 0, 0, 1, 0, 1, 1, 32'h94, 32'h0, 5'd6, 1000, 32'h0);
    m_read = 32'hDEADBEEF;
    m_err = 1'b1;
    run_op(o, TMO + 1, m_read, m_read, 1'b0, 1'b0);
    o = mk_op(0, 0, 0, 0, 0, 0, 1, 32'h98, 32'h0, 5'd1, 0, 32'h0);
    run_op(o, 0, m_read, 32'h98, 1'b0, 1'b1);
`else
    @(negedge CLK);
    apply(mk_op(0, 0, 0, 1, 0, 1, 1, 32'h94, 32'h0, 5'd6, 0, 32'h0));
    for (int c = 0; c < 24; c++) begin
      #1;
      check("hang_stall", Mem_Stall, 1'b1);
      check("hang_req", DMem_Req, c != 0);
      @(negedge CLK);
    end
    check("hang_err", Mem_Err, 1'b0);
    RST = 1'b0;
    #1;
    check("hang_reset_req", DMem_Req, 1'b0);
    apply(mk_op(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0));
    @(negedge CLK);
    RST = 1'b1;
`endif

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage 4 (memory access). Sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Performs data-memory loads and stores over a req/ack handshake, stalling the pipeline while an access is outstanding.
- Resolves branch/jump redirect and owns the MEM/WB pipeline register.
- Drives the write-back value (Wb_Data) that feeds the execute-stage forwarding input Dst_FeedBack.

Parameters:
- size, 32, data/address width.
- TIMEOUT_CYCLES, 16, maximum REQ cycles without DMem_Ack before abort (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite  in  1 each  control bits from the EX/MEM register.
- ExMem_AluOut  in  size  ALU result; used as the memory address.
- ExMem_ZeroFlag  in  1  ALU zero flag.
- ExMem_DataRt  in  32  store data.
- ExMem_AddrRdRt  in  5  destination register.
- DMem_Req  out  1  memory request.
- DMem_We  out  1  1 = write.
- DMem_Addr  out  size  access address.
- DMem_WData  out  32  write data.
- DMem_Ack  in  1  memory acknowledge.
- DMem_RData  in  32  read data, valid with DMem_Ack.
- Mem_Stall  out  1  freeze IF/ID/EX stages.
- PCSrc  out  1  branch taken.
- Jump_Taken  out  1  jump present.
- Flush_Out  out  1  flush younger stages.
- MemWb_RegWrite, MemWb_MemtoReg  out  1 each  MEM/WB control.
- MemWb_ReadData  out  32  load data.
- MemWb_AluOut  out  size  ALU result.
- MemWb_AddrRdRt  out  5  destination register.
- Wb_Data  out  32  write-back value.
- Mem_Err  out  1  sticky access-timeout error (optional feature only).

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE.
  - Every registered output clears to 0, including DMem_Req and Mem_Err.
  - Reset mid-access abandons the access. Memory must tolerate a dropped request.
- Access pending = ExMem_MemRead | ExMem_MemWrite. If both bits are set, the write wins: DMem_We=1 and no read data is captured.
- FSM states IDLE, REQ, DONE:
  - IDLE, no access pending: Mem_Stall=0. The MEM/WB register loads every edge. Latency is 1 cycle.
  - IDLE, access pending: Mem_Stall=1 combinationally; next state REQ.
  - REQ: DMem_Req=1. DMem_Addr, DMem_We and DMem_WData are registered and held constant until ack. Mem_Stall=1.
    - On DMem_Ack=1: capture DMem_RData into a load buffer; next state DONE.
    - On DMem_Ack=0: stay in REQ.
  - DONE: DMem_Req=0 and Mem_Stall=0. The MEM/WB register loads, taking ReadData from the load buffer. Next state IDLE.
  - Minimum load/store latency is 3 cycles (IDLE, REQ with immediate ack, DONE).
- While Mem_Stall=1, the MEM/WB register loads a bubble: MemWb_RegWrite=0, all other MemWb fields hold their previous values.
- DMem_Ack outside REQ is ignored.
- PCSrc = ExMem_Branch & ExMem_ZeroFlag, combinational.
- Jump_Taken = ExMem_Jump, combinational.
- Flush_Out = PCSrc | Jump_Taken, forced to 0 while Mem_Stall=1.
- MEM/WB load (when not stalled):
  - RegWrite, MemtoReg, AluOut and AddrRdRt copy their ExMem_* inputs.
  - ReadData takes the load buffer for a load, otherwise holds its value.
- Wb_Data = MemWb_MemtoReg ? MemWb_ReadData : MemWb_AluOut, combinational.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter (clog2(TIMEOUT_CYCLES)+1 bits) clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: DMem_Req drops, the load buffer takes 32'hDEADBEEF, the FSM goes to DONE, and Mem_Err sets and stays set until reset.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- Undefined: no counter. REQ waits indefinitely for ack. Mem_Err is tied to 0.

Test Plan:
- Reset with RST=0 mid-REQ (DMem_Req=1) -> DMem_Req=0, Mem_Stall=0, all MemWb_* outputs 0 immediately, FSM in IDLE after release.
- ALU-only op (AluOut=32'h10, RegWrite=1, AddrRdRt=5'd3, MemtoReg=0) -> next edge MemWb_AluOut=32'h10, MemWb_AddrRdRt=3, Wb_Data=32'h10, Mem_Stall never asserted.
- Load (MemRead=1, AluOut=32'h40, MemtoReg=1), ack after 2 REQ cycles with RData=32'hCAFE0001:
  - DMem_Addr=32'h40 held stable throughout REQ.
  - Mem_Stall high for 3 cycles, MemWb_RegWrite=0 during the stall.
  - Then MemWb_ReadData=32'hCAFE0001 and Wb_Data=32'hCAFE0001.
- Store (MemWrite=1, DataRt=32'h55AA, AluOut=32'h8), ack immediately -> DMem_We=1, DMem_WData=32'h55AA, DMem_Addr=32'h8, Mem_Stall high for exactly 2 cycles.
- Branch=1 with ZeroFlag=1, then Branch=1 with ZeroFlag=0 -> PCSrc=1 and Flush_Out=1 for the first; PCSrc=0 for the second.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, load with no ack -> DMem_Req falls after 4 REQ cycles, Mem_Err=1 (sticky), MemWb_ReadData=32'hDEADBEEF. With the macro undefined, the same stimulus keeps Mem_Stall=1 indefinitely.
